uart_wb_arbiter: RTL and testbench
==================================

Name: uart_wb_arbiter

Overview:
Round-robin Wishbone arbiter that shares the single UART slave port between NUM_MASTERS requesters, e.g. the CPU and a debug/loader engine.
Sits between the masters and the UART register interface: TX at 0x0, RX at 0x1, frequency divider at 0x2.
Preserves the UART's four-phase strobe/ack handshake end to end.
Adds a per-transaction timeout so a hung slave cannot lock the bus.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8).
TIMEOUT_CYCLES, 255, wb_clk cycles in GRANT without s_ack before the error path is taken; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
wb_clk  in  1  Wishbone clock; all logic is on its rising edge.
reset  in  1  synchronous, active-high.
m_stb  in  NUM_MASTERS  per-master strobe.
m_we  in  NUM_MASTERS  per-master we. LOW = write to UART, HIGH = read from UART.
m_addr  in  2*NUM_MASTERS  packed; master i uses bits [2i+1:2i].
m_data_in  in  8*NUM_MASTERS  packed write data.
m_data_out  out  8  read data, broadcast to all masters.
m_ack  out  NUM_MASTERS  per-master ack.
m_err  out  NUM_MASTERS  per-master timeout error.
s_stb  out  1  strobe to UART.
s_we  out  1  we to UART.
s_addr  out  2  address to UART.
s_data_out  out  8  write data to UART.
s_data_in  in  8  read data from UART.
s_ack  in  1  ack from UART.
grant  out  NUM_MASTERS  one-hot current owner; all zero when IDLE.

Behaviour:
- Reset:
  - state = IDLE; grant = 0; s_stb = s_we = 0; s_addr = 0; s_data_out = 0.
  - m_ack = m_err = 0; timeout counter = 0.
  - last_grant = NUM_MASTERS-1, so master 0 wins the first arbitration.
  - Reset asserted mid-transaction aborts it; no ack or err is issued for it.
- States: IDLE, GRANT, DRAIN, ERROR. A registered owner index g is held for the whole transaction.
- IDLE:
  - If any m_stb is high, select the first requester scanning from last_grant+1 and wrapping modulo NUM_MASTERS.
  - Register g and move to GRANT. The request seen at edge n drives s_stb high from edge n+1 (1-cycle arbitration latency).
  - All other masters are ignored until return to IDLE.
- GRANT:
  - s_stb = m_stb[g]; s_we, s_addr and s_data_out are muxed from master g (combinational from the registered g).
  - m_ack[g] = s_ack; m_data_out = s_data_in.
  - Counter increments each cycle while s_ack = 0 and clears when s_ack = 1.
  - If m_stb[g] = 0, go to DRAIN. This covers both normal completion and a master abandoning the transaction.
  - Else if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 with s_ack still 0, go to ERROR.
- DRAIN:
  - s_stb = 0; m_ack[g] = s_ack.
  - When s_ack = 0, set last_grant = g and go to IDLE. Arbitration resumes on the following edge.
- ERROR:
  - s_stb = 0; m_err[g] = 1 and is held (four-phase) until m_stb[g] = 0.
  - Then wait for s_ack = 0, set last_grant = g and go to IDLE.
- Outputs in IDLE: s_stb, s_we, s_addr and s_data_out are 0. m_data_out holds its last value.
- m_ack and m_err are never asserted to a non-owner. m_ack and m_err are never both high for the same master.
- Fairness: with all masters requesting continuously, each master gets exactly one transaction per NUM_MASTERS transactions.
- Simultaneous events:
  - A new request arriving while in DRAIN is queued implicitly by being sampled in IDLE.
  - The owner re-raising m_stb in the same cycle DRAIN exits gets no priority; round-robin order applies.

Decomposition:
- Package uart_wb_pkg holds:
  - UART register address constants: TX_DATA = 2'b00, RX_DATA = 2'b01, FREQ_DIV = 2'b10.
  - Arbiter state encodings: IDLE, GRANT, DRAIN, ERROR.
  - The WE_WRITE = 0 / WE_READ = 1 polarity constants.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: request vector, last_grant index.
  - Outputs: selected index and a valid flag.
  - Reused later by other shared-peripheral arbiters.

Test Plan:
1. Single master: master 0 writes 0x41 to addr 0, UART acks 1 cycle after s_stb. Required: s_stb high 1 cycle after m_stb[0]; s_data_out = 0x41 and s_we = 0; m_ack[0] follows s_ack; grant returns to 0 after ack drops.
2. Contention: both masters raise m_stb on the same edge after reset. Required: master 0 is served first; master 1 is granted on the IDLE cycle after master 0's DRAIN; m_ack[1] is never high during master 0's transaction.
3. Fairness: both masters request continuously for 8 transactions. Required: grant order 0,1,0,1,0,1,0,1.
4. Read: master 1 reads addr 1 and the UART returns 0x5A. Required: m_data_out = 0x5A while m_ack[1] is high; s_we = 1.
5. Timeout: TIMEOUT_CYCLES = 4 and s_ack tied low. Required: s_stb high for 4 cycles, then low; m_err[0] = 1 until m_stb[0] drops; IDLE next; m_ack stays 0 throughout.
6. Reset in GRANT: reset is asserted for 1 cycle while s_ack is high. Required: all outputs are 0 on the next cycle and master 0 holds first priority again.

Source files
------------

// File: rtl/uart_wb_pkg.sv
// Shared definitions for the UART Wishbone arbiter: UART register map,
// strobe direction polarity and arbiter state encodings.
package uart_wb_pkg;

  localparam logic [1:0] TX_DATA  = 2'b00;
  localparam logic [1:0] RX_DATA  = 2'b01;
  localparam logic [1:0] FREQ_DIV = 2'b10;

  localparam logic WE_WRITE = 1'b0;
  localparam logic WE_READ  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2,
    ERROR = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after
// 'last', wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  logic [IW-1:0] cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last) + k) % N_REQ);
      if (!valid && req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one UART register port between
// NUM_MASTERS requesters, with a per-transaction timeout.
module uart_wb_arbiter
  import uart_wb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                     wb_clk,
  input  logic                     reset,
  input  logic [NUM_MASTERS-1:0]   m_stb,
  input  logic [NUM_MASTERS-1:0]   m_we,
  input  logic [2*NUM_MASTERS-1:0] m_addr,
  input  logic [8*NUM_MASTERS-1:0] m_data_in,
  output logic [7:0]               m_data_out,
  output logic [NUM_MASTERS-1:0]   m_ack,
  output logic [NUM_MASTERS-1:0]   m_err,
  output logic                     s_stb,
  output logic                     s_we,
  output logic [1:0]               s_addr,
  output logic [7:0]               s_data_out,
  input  logic [7:0]               s_data_in,
  input  logic                     s_ack,
  output logic [NUM_MASTERS-1:0]   grant
);

  localparam int                IW        = $clog2(NUM_MASTERS);
  localparam logic [IW-1:0]     LAST_RST  = IW'(NUM_MASTERS - 1);
  localparam int                TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0]  TO_LAST   = TO_LAST_I[CNT_W-1:0];
  localparam logic              TO_EN     = (TIMEOUT_CYCLES != 0);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    g_q, g_d;
  logic [IW-1:0]    last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_rel_q, err_rel_d;
  logic [7:0]       data_q, data_d;

  logic [IW-1:0]    pick_idx;
  logic             pick_valid;
  logic             sel_stb, sel_we;
  logic [1:0]       sel_addr;
  logic [7:0]       sel_data;

  rr_pick #(
    .N_REQ (NUM_MASTERS),
    .IW    (IW)
  ) u_pick (
    .req   (m_stb),
    .last  (last_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign sel_stb  = m_stb[g_q];
  assign sel_we   = m_we[g_q];
  assign sel_addr = m_addr[{g_q, 1'b0} +: 2];
  assign sel_data = m_data_in[{g_q, 3'b000} +: 8];

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    err_rel_d = err_rel_q;
    data_d    = data_q;
    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        err_rel_d = 1'b0;
        if (pick_valid) begin
          g_d     = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        data_d = s_data_in;
        cnt_d  = s_ack ? '0 : cnt_q + 1'b1;
        if (!sel_stb) begin
          state_d = DRAIN;
        end else if (TO_EN && !s_ack && (cnt_q == TO_LAST)) begin
          state_d = ERROR;
        end
      end
      DRAIN: begin
        if (!s_ack) begin
          last_d  = g_q;
          state_d = IDLE;
        end
      end
      ERROR: begin
        // The error stays up until the master lets go; after that only the slave's ack matters.
        if (!sel_stb) err_rel_d = 1'b1;
        if ((!sel_stb || err_rel_q) && !s_ack) begin
          last_d  = g_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      g_q       <= '0;
      last_q    <= LAST_RST;
      cnt_q     <= '0;
      err_rel_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      err_rel_q <= err_rel_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    s_stb      = 1'b0;
    s_we       = WE_WRITE;
    s_addr     = TX_DATA;
    s_data_out = '0;
    m_ack      = '0;
    m_err      = '0;
    grant      = '0;
    m_data_out = data_q;
    if (state_q != IDLE) grant[g_q] = 1'b1;
    unique case (state_q)
      GRANT: begin
        s_stb      = sel_stb;
        s_we       = sel_we;
        s_addr     = sel_addr;
        s_data_out = sel_data;
        m_ack[g_q] = s_ack;
        m_data_out = s_data_in;
      end
      DRAIN:   m_ack[g_q] = s_ack;
      ERROR:   m_err[g_q] = sel_stb && !err_rel_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Randomised self-checking bench for uart_wb_arbiter: an ownership-level
// reference model predicts every output each cycle, plus directed scenarios.
module tb_uart_wb_arbiter;
  import uart_wb_pkg::*;

  localparam int N  = 2;
  localparam int TO = 4;

  logic           wb_clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   m_stb = '0;
  logic [N-1:0]   m_we = '0;
  logic [2*N-1:0] m_addr = '0;
  logic [8*N-1:0] m_data_in = '0;
  logic [7:0]     m_data_out;
  logic [N-1:0]   m_ack, m_err, grant;
  logic           s_stb, s_we;
  logic [1:0]     s_addr;
  logic [7:0]     s_data_out;
  logic [7:0]     s_data_in = '0;
  logic           s_ack = 1'b0;

  uart_wb_arbiter #(
    .NUM_MASTERS    (N),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (8)
  ) dut (
    .wb_clk     (wb_clk),
    .reset      (reset),
    .m_stb      (m_stb),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_data_in  (m_data_in),
    .m_data_out (m_data_out),
    .m_ack      (m_ack),
    .m_err      (m_err),
    .s_stb      (s_stb),
    .s_we       (s_we),
    .s_addr     (s_addr),
    .s_data_out (s_data_out),
    .s_data_in  (s_data_in),
    .s_ack      (s_ack),
    .grant      (grant)
  );

  always #5 wb_clk = ~wb_clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: who owns the UART and which phase of ownership it is in.
  int         own = -1;
  int         last_own = N - 1;
  bit         closing = 1'b0;
  bit         timed_out = 1'b0;
  bit         let_go = 1'b0;
  int         waited = 0;
  logic [7:0] held = '0;

  task automatic modelStep();
    if (reset) begin
      own = -1; last_own = N - 1; closing = 0; timed_out = 0; let_go = 0; waited = 0; held = '0;
    end else if (own < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last_own + k) % N;
        if (own < 0 && m_stb[c]) own = c;
      end
      closing = 0; timed_out = 0; let_go = 0; waited = 0;
    end else if (timed_out) begin
      let_go = let_go || !m_stb[own];
      if (let_go && !s_ack) begin last_own = own; own = -1; end
    end else if (closing) begin
      if (!s_ack) begin last_own = own; own = -1; end
    end else begin
      held = s_data_in;
      if (!m_stb[own]) closing = 1;
      else if (s_ack) waited = 0;
      else begin
        if (waited == TO - 1) timed_out = 1;
        waited++;
      end
    end
  endtask

  task automatic checkAll();
    logic [N-1:0] e_grant, e_ack, e_err;
    logic         e_stb, e_we;
    logic [1:0]   e_addr;
    logic [7:0]   e_data, e_dout;
    e_grant = '0; e_ack = '0; e_err = '0;
    e_stb = 0; e_we = 0; e_addr = '0; e_data = '0; e_dout = held;
    if (own >= 0) begin
      e_grant[own] = 1'b1;
      if (!closing && !timed_out) begin
        e_stb  = m_stb[own];
        e_we   = m_we[own];
        e_addr = m_addr[2*own +: 2];
        e_data = m_data_in[8*own +: 8];
        e_dout = s_data_in;
      end
      if (!timed_out) e_ack[own] = s_ack;
      else e_err[own] = m_stb[own] && !let_go;
    end
    checkOutput("grant", grant, e_grant);
    checkOutput("s_stb", s_stb, e_stb);
    checkOutput("s_we", s_we, e_we);
    checkOutput("s_addr", s_addr, e_addr);
    checkOutput("s_data_out", s_data_out, e_data);
    checkOutput("m_ack", m_ack, e_ack);
    checkOutput("m_err", m_err, e_err);
    checkOutput("m_data_out", m_data_out, e_dout);
  endtask

  // Reactive master and UART behaviour.
  bit masters_on = 0;
  int want_pct = 0;
  int abandon_pct = 0;
  int slave_delay = -1;
  bit slave_hung = 0;
  int slave_fix = -1;
  int wait_cnt = 0;
  int cur_delay = 0;

  function automatic int pickDelay();
    int r;
    r = int'($urandom_range(19));
    return (r == 0) ? 6 : (r % 4);
  endfunction

  task automatic applyStimulus();
    if (s_stb && !s_ack) begin
      if (wait_cnt == 0) cur_delay = (slave_delay >= 0) ? slave_delay : pickDelay();
      if (!slave_hung && wait_cnt >= cur_delay) begin
        s_ack = 1'b1;
        s_data_in = (slave_fix >= 0) ? 8'(slave_fix) : 8'($urandom);
      end else begin
        wait_cnt++;
      end
    end else if (!s_stb) begin
      s_ack = 1'b0;
      wait_cnt = 0;
    end
    if (masters_on) begin
      for (int i = 0; i < N; i++) begin
        if (m_stb[i]) begin
          if (m_ack[i] || m_err[i]) m_stb[i] = 1'b0;
          else if (abandon_pct > 0 && int'($urandom_range(99)) < abandon_pct) m_stb[i] = 1'b0;
        end else if (!m_ack[i] && !m_err[i] && int'($urandom_range(99)) < want_pct) begin
          m_stb[i] = 1'b1;
          m_we[i] = 1'($urandom_range(1));
          m_addr[2*i +: 2] = 2'($urandom_range(2));
          m_data_in[8*i +: 8] = 8'($urandom);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    modelStep();
    #1 applyStimulus();
    #1 checkAll();
  endtask

  task automatic quiesce();
    int n;
    n = 0;
    masters_on = 0;
    m_stb = '0;
    while ((grant != '0 || s_ack) && n < 50) begin
      tick();
      n++;
    end
    checkOutput("quiesce", {grant, s_ack}, '0);
  endtask

  initial begin
    int n, hi, got;
    logic [N-1:0] prev;
    int order[8];

    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    checkOutput("rst_grant", grant, '0);
    checkOutput("rst_s_stb", s_stb, 0);
    checkOutput("rst_m_ack", m_ack, '0);
    checkOutput("rst_m_err", m_err, '0);

    // Single master write
    slave_delay = 1;
    m_stb[0] = 1'b1; m_we[0] = WE_WRITE; m_addr[1:0] = TX_DATA; m_data_in[7:0] = 8'h41;
    #1 checkOutput("t1_stb_pre", s_stb, 0);
    tick();
    checkOutput("t1_stb", s_stb, 1);
    checkOutput("t1_data", s_data_out, 8'h41);
    checkOutput("t1_we", s_we, WE_WRITE);
    n = 0;
    while (!m_ack[0] && n < 10) begin tick(); n++; end
    checkOutput("t1_ack", m_ack[0], 1);
    m_stb[0] = 1'b0;
    n = 0;
    while (grant != '0 && n < 10) begin tick(); n++; end
    checkOutput("t1_release", grant, '0);

    // Contention straight after reset, then fairness under continuous requests
    reset = 1'b1;
    tick();
    reset = 1'b0;
    masters_on = 1; want_pct = 100; abandon_pct = 0;
    prev = '0; got = 0; n = 0;
    while (got < 8 && n < 300) begin
      tick();
      n++;
      if (prev == '0 && grant != '0) begin
        order[got] = (grant == 2'b10) ? 1 : 0;
        got++;
      end
      prev = grant;
    end
    checkOutput("fair_count", got, 8);
    for (int k = 0; k < got; k++) checkOutput($sformatf("fair_order%0d", k), order[k], k % 2);
    quiesce();

    // Read from RX by master 1
    slave_fix = 8'h5A;
    m_stb[1] = 1'b1; m_we[1] = WE_READ; m_addr[3:2] = RX_DATA; m_data_in[15:8] = 8'($urandom);
    n = 0;
    while (!m_ack[1] && n < 10) begin tick(); n++; end
    checkOutput("t4_ack", m_ack[1], 1);
    checkOutput("t4_rdata", m_data_out, 8'h5A);
    checkOutput("t4_we", s_we, WE_READ);
    checkOutput("t4_addr", s_addr, RX_DATA);
    m_stb[1] = 1'b0;
    quiesce();
    slave_fix = -1;

    // Timeout with a hung UART
    slave_hung = 1;
    m_stb[0] = 1'b1; m_we[0] = WE_WRITE; m_addr[1:0] = FREQ_DIV; m_data_in[7:0] = 8'h03;
    n = 0; hi = 0;
    while (!m_err[0] && n < 20) begin
      tick();
      n++;
      if (s_stb) hi++;
    end
    checkOutput("t5_stb_cycles", hi, TO);
    checkOutput("t5_err", m_err[0], 1);
    tick();
    checkOutput("t5_err_hold", m_err[0], 1);
    m_stb[0] = 1'b0;
    #1 checkOutput("t5_err_drop", m_err, '0);
    tick();
    checkOutput("t5_idle", grant, '0);
    slave_hung = 0;

    // Reset while the UART is acking master 0
    slave_delay = 0;
    m_stb[0] = 1'b1; m_we[0] = WE_WRITE; m_addr[1:0] = TX_DATA; m_data_in[7:0] = 8'h77;
    n = 0;
    while (!m_ack[0] && n < 10) begin tick(); n++; end
    checkOutput("t6_ack", m_ack[0], 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t6_grant", grant, '0);
    checkOutput("t6_stb", s_stb, 0);
    checkOutput("t6_sdata", s_data_out, 0);
    checkOutput("t6_ack0", m_ack, '0);
    checkOutput("t6_err0", m_err, '0);
    checkOutput("t6_dout", m_data_out, 0);
    m_stb = 2'b11; m_we[1] = WE_READ; m_addr[3:2] = RX_DATA;
    tick();
    checkOutput("t6_prio", grant, 2'b01);
    quiesce();

    // Random traffic with abandons, occasional hung slave and stray resets
    masters_on = 1; want_pct = 35; abandon_pct = 3; slave_delay = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(499) == 0);
      tick();
    end
    reset = 1'b0;
    quiesce();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
